// File: rtl/obf_seq_detector.sv
// Key-gated serial pattern detector: a serial key unlocks pattern matching,
// and too many wrong keys lock the block permanently until reset.
module obf_seq_detector #(
    parameter int unsigned          KEY_LEN   = 5,
    parameter logic [KEY_LEN-1:0]   KEY       = 5'b01110,
    parameter int unsigned          PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN   = 4'b1101,
    parameter int unsigned          MAX_TRIES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic x,
    input  logic en,
    input  logic relock,
    output logic out,
    output logic unlocked,
    output logic dead
);

    localparam int unsigned IDX_W  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);

    typedef enum logic [1:0] {
        KEY_CHK   = 2'd0,
        FUNC      = 2'd1,
        BLACKHOLE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [TRY_W-1:0]    tries, tries_n;
    logic [PAT_LEN-1:0]  hist, hist_n;
    logic [FILL_W-1:0]   fill, fill_n;
    logic                out_n;
    logic [KEY_LEN-1:0]  key_sh;
    logic                key_bit;

    // Expected key bit: KEY is consumed MSB first.
    always_comb begin
        key_sh  = KEY << idx;
        key_bit = key_sh[KEY_LEN-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= KEY_CHK;
            idx      <= '0;
            tries    <= '0;
            hist     <= '0;
            fill     <= '0;
            out      <= 1'b0;
            unlocked <= 1'b0;
            dead     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            tries    <= tries_n;
            hist     <= hist_n;
            fill     <= fill_n;
            out      <= out_n;
            unlocked <= (state_n == FUNC);
            dead     <= (state_n == BLACKHOLE);
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        tries_n = tries;
        hist_n  = hist;
        fill_n  = fill;
        out_n   = 1'b0;
        case (state)
            KEY_CHK: begin
                if (en) begin
                    if (x == key_bit) begin
                        if (idx == IDX_W'(KEY_LEN - 1)) begin
                            state_n = FUNC;
                            idx_n   = '0;
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        // Wrong bit restarts the key; it is not reused as a first bit.
                        idx_n   = '0;
                        tries_n = tries + TRY_W'(1);
                        if (tries_n == TRY_W'(MAX_TRIES)) begin
                            state_n = BLACKHOLE;
                        end
                    end
                end
            end
            FUNC: begin
                if (relock) begin
                    state_n = KEY_CHK;
                    idx_n   = '0;
                    tries_n = '0;
                    hist_n  = '0;
                    fill_n  = '0;
                end else if (en) begin
                    hist_n = PAT_LEN'({hist, x});
                    fill_n = (fill == FILL_W'(PAT_LEN)) ? fill : fill + FILL_W'(1);
                    out_n  = (hist_n == PATTERN) && (fill_n == FILL_W'(PAT_LEN));
                end
            end
            BLACKHOLE: begin
            end
            default: begin
                state_n = KEY_CHK;
            end
        endcase
    end

endmodule

// File: tb/tb_obf_seq_detector.sv
// Randomized and directed bench for obf_seq_detector against a bit-queue reference model.
module tb_obf_seq_detector;

    localparam int unsigned KEY_LEN   = 5;
    localparam int unsigned PAT_LEN   = 4;
    localparam int unsigned MAX_TRIES = 2;

    logic [KEY_LEN-1:0] key_v = 5'b01110;
    logic [PAT_LEN-1:0] pat_v = 4'b1101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic x = 1'b0;
    logic en = 1'b0;
    logic relock = 1'b0;
    logic out, unlocked, dead;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: 0 = key entry, 1 = functional, 2 = locked out.
    int m_mode = 0;
    int m_idx = 0;
    int m_tries = 0;
    bit m_hist[$];
    bit m_out = 1'b0;

    obf_seq_detector dut (
        .clk(clk),
        .rst_n(rst_n),
        .x(x),
        .en(en),
        .relock(relock),
        .out(out),
        .unlocked(unlocked),
        .dead(dead)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_idx = 0;
        m_tries = 0;
        m_hist.delete();
        m_out = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit xi, input bit rl);
        bit match;
        m_out = 1'b0;
        if (m_mode == 2) begin
        end else if (m_mode == 1 && rl) begin
            model_reset();
        end else if (e) begin
            if (m_mode == 0) begin
                if (xi == key_v[KEY_LEN-1-m_idx]) begin
                    m_idx++;
                    if (m_idx == KEY_LEN) begin
                        m_mode = 1;
                        m_idx = 0;
                    end
                end else begin
                    m_idx = 0;
                    m_tries++;
                    if (m_tries == MAX_TRIES) m_mode = 2;
                end
            end else begin
                m_hist.push_back(xi);
                if (m_hist.size() > PAT_LEN) void'(m_hist.pop_front());
                if (m_hist.size() == PAT_LEN) begin
                    match = 1'b1;
                    for (int i = 0; i < PAT_LEN; i++)
                        if (m_hist[i] != pat_v[PAT_LEN-1-i]) match = 1'b0;
                    m_out = match;
                end
            end
        end
    endtask

    // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input string tag, input bit e, input bit xi, input bit rl);
        en = e;
        x = xi;
        relock = rl;
        @(posedge clk);
        model_edge(e, xi, rl);
        #1;
        check(tag, {29'd0, out, unlocked, dead},
              {29'd0, m_out, (m_mode == 1), (m_mode == 2)});
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        en = 1'b0;
        relock = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check(tag, {29'd0, out, unlocked, dead}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic enter_key(input string tag);
        for (int i = KEY_LEN - 1; i >= 0; i--) step(tag, 1'b1, key_v[i], 1'b0);
    endtask

    task automatic send_bits(input string tag, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i], 1'b0);
    endtask

    initial begin
        #1;
        do_reset("reset");

        // Unlock with the default key.
        enter_key("unlock");
        check("unlock_const", {29'd0, out, unlocked, dead}, 32'b010);

        // Overlapping pattern: pulses after bits 4 and 7 only.
        send_bits("overlap", 16'b1101101, 7);
        check("overlap_last", {31'd0, out}, 32'd1);

        // One wrong bit, then the full key.
        do_reset("reset2");
        step("wrong1", 1'b1, 1'b1, 1'b0);
        enter_key("retry");
        check("retry_unlocked", {31'd0, unlocked}, 32'd1);

        // Two wrong bits lock out; keys and relock are ignored.
        do_reset("reset3");
        send_bits("lockout", 16'b11, 2);
        check("dead_const", {31'd0, dead}, 32'd1);
        enter_key("dead_key");
        step("dead_relock", 1'b1, 1'b1, 1'b1);
        send_bits("dead_pat", 16'b1101, 4);
        do_reset("reset_dead");

        // Relock wins over a simultaneous bit; history restarts empty.
        enter_key("unlock4");
        send_bits("pre_relock", 16'b110, 3);
        step("relock", 1'b1, 1'b1, 1'b1);
        check("relock_const", {29'd0, out, unlocked, dead}, 32'd0);
        enter_key("unlock5");
        step("fresh_hist", 1'b1, 1'b1, 1'b0);
        check("fresh_nopulse", {31'd0, out}, 32'd0);
        send_bits("fresh_pat", 16'b101, 3);
        check("fresh_pulse", {31'd0, out}, 32'd1);

        // en gaps hold everything; then async reset mid-cycle.
        do_reset("reset6");
        enter_key("unlock6");
        step("gap", 1'b1, 1'b1, 1'b0);
        step("gap", 1'b0, 1'b0, 1'b0);
        step("gap", 1'b1, 1'b1, 1'b0);
        step("gap", 1'b0, 1'b1, 1'b0);
        step("gap", 1'b1, 1'b0, 1'b0);
        step("gap", 1'b0, 1'b0, 1'b0);
        step("gap", 1'b1, 1'b1, 1'b0);
        check("gap_pulse", {31'd0, out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {29'd0, out, unlocked, dead}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic, mostly correct key bits so FUNC is reached often.
        for (int n = 0; n < 3000; n++) begin
            bit e, xi, rl;
            if ((n % 250) == 249) begin
                do_reset("rand_reset");
            end else begin
                e  = ($urandom % 4) != 0;
                rl = ($urandom % 40) == 0;
                if (m_mode == 0 && ($urandom % 10) != 0)
                    xi = key_v[KEY_LEN-1-m_idx];
                else if (m_mode == 1 && ($urandom % 2) == 0)
                    xi = pat_v[PAT_LEN-1-($urandom % PAT_LEN)];
                else
                    xi = 1'($urandom % 2);
                step("random", e, xi, rl);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
